// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and prescaler sizing for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} sw_state_t;
  function automatic int presc_w(input int div);
    return div <= 2 ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: DIV-cycle prescaler; ports clk, rst_n, en (count), load0 (force zero), presc, tick (last count while enabled)
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load0,
  output logic [presc_w(DIV)-1:0] presc,
  output logic                    tick
);
  localparam int W = presc_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  assign tick = en && presc == LAST;
  always_ff @(posedge clk)
    if (!rst_n || load0) presc <= '0;
    else if (en) presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM driving a two-digit BCD counter; ports clk, rst_n, start_stop, clear, units, tens -> cnt_en, cnt_rst_n, running, done, state
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV         = 1_000_000,
  parameter int LIMIT_TENS  = 5,
  parameter int LIMIT_UNITS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic       cnt_en,
  output logic       cnt_rst_n,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);
  localparam logic [7:0] LIM = {4'(LIMIT_TENS), 4'(LIMIT_UNITS)};
  sw_state_t st;
  logic hit, tick;
  logic [presc_w(DIV)-1:0] presc;
  assign hit = st == RUN && {tens, units} == LIM;
  assign running = st == RUN;
  assign done = st == DONE;
  assign state = st;
  // IDLE and DONE keep the prescaler zeroed, so IDLE->RUN always starts a fresh period
  tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .en(st == RUN),
    .load0(clear || st == IDLE || st == DONE),
    .presc(presc),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= IDLE;
      cnt_en <= 1'b0;
      cnt_rst_n <= 1'b0;
    end else begin
      cnt_rst_n <= !clear;
      cnt_en <= tick && !clear && !hit;
      if (clear) st <= IDLE;
      else if (hit) st <= DONE;
      else if (start_stop) st <= (st == IDLE || st == PAUSE) ? RUN : st == RUN ? PAUSE : st;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table + scoreboard check of stopwatch_ctrl with DIV=4, limit 03 and a BCD counter attached
module tb_stopwatch_ctrl;
  localparam logic [1:0] I = 2'b00, R = 2'b01, P = 2'b10, D = 2'b11;
  typedef struct {
    logic r, s, c;
    logic [1:0] st;
    logic en, crn;
    logic [7:0] cnt;
    int p;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] units, tens;
  logic cnt_en, cnt_rst_n, running, done;
  logic [1:0] state;
  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stopwatch_ctrl #(.DIV(4), .LIMIT_TENS(0), .LIMIT_UNITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
    .units(units), .tens(tens), .cnt_en(cnt_en), .cnt_rst_n(cnt_rst_n),
    .running(running), .done(done), .state(state)
  );
  always_ff @(posedge clk)
    if (!cnt_rst_n) begin
      units <= 4'd0;
      tens <= 4'd0;
    end else if (cnt_en) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else units <= units + 4'd1;
    end
  function automatic void add(input logic r, s, c, input logic [1:0] st, input logic en, crn,
                              input logic [7:0] cnt, input int p);
    vecs.push_back('{r, s, c, st, en, crn, cnt, p});
  endfunction
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask
  initial begin
    vec_t e;
    add(0,0,0,I,0,0,8'hFF,0);
    add(0,0,0,I,0,0,8'h00,0);
    add(1,1,0,R,0,1,8'h00,0);
    add(1,0,0,R,0,1,8'h00,1);
    add(1,0,0,R,0,1,8'h00,2);
    add(1,0,0,R,0,1,8'h00,3);
    add(1,0,0,R,1,1,8'h00,0);
    add(1,0,0,R,0,1,8'h01,1);
    add(1,0,0,R,0,1,8'h01,2);
    add(1,0,0,R,0,1,8'h01,3);
    add(1,0,0,R,1,1,8'h01,0);
    add(1,0,0,R,0,1,8'h02,1);
    add(1,0,0,R,0,1,8'h02,2);
    add(1,0,0,R,0,1,8'h02,3);
    add(1,0,0,R,1,1,8'h02,0);
    add(1,0,0,R,0,1,8'h03,1);
    add(1,1,0,D,0,1,8'h03,-1);
    for (int i = 0; i < 2; i++) add(1,0,0,D,0,1,8'h03,0);
    for (int i = 0; i < 3; i++) add(1,1,0,D,0,1,8'h03,0);
    add(1,0,1,I,0,0,8'h03,0);
    add(1,0,0,I,0,1,8'h00,0);
    add(1,1,0,R,0,1,8'h00,0);
    add(1,0,0,R,0,1,8'h00,1);
    add(1,1,0,P,0,1,8'h00,2);
    for (int i = 0; i < 10; i++) add(1,0,0,P,0,1,8'h00,2);
    add(1,1,0,R,0,1,8'h00,2);
    add(1,0,0,R,0,1,8'h00,3);
    add(1,0,0,R,1,1,8'h00,0);
    add(1,0,0,R,0,1,8'h01,1);
    add(1,0,0,R,0,1,8'h01,2);
    add(1,0,0,R,0,1,8'h01,3);
    add(1,0,0,R,1,1,8'h01,0);
    add(1,0,0,R,0,1,8'h02,1);
    add(1,0,0,R,0,1,8'h02,2);
    add(1,0,0,R,0,1,8'h02,3);
    add(1,0,1,I,0,0,8'h02,0);
    add(1,0,0,I,0,1,8'h00,0);
    add(1,1,1,I,0,0,8'h00,0);
    add(1,0,0,I,0,1,8'h00,0);
    add(1,0,0,I,0,1,8'h00,0);
    for (int k = 0; k < 2; k++) begin
      add(1,1,0,R,0,1,8'h00,0);
      add(1,0,0,R,0,1,8'h00,1);
      add(1,0,0,R,0,1,8'h00,2);
      add(1,0,0,R,0,1,8'h00,3);
      add(1,0,0,R,1,1,8'h00,0);
      add(1,0,0,R,0,1,8'h01,1);
      if (k == 0) begin
        add(0,1,0,I,0,0,8'h01,0);
        add(1,0,0,I,0,1,8'h00,0);
      end
    end
    foreach (vecs[n]) begin
      rst_n = vecs[n].r;
      start_stop = vecs[n].s;
      clear = vecs[n].c;
      sb.push_back(vecs[n]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("state", n, 32'(state), 32'(e.st));
      chk("cnt_en", n, 32'(cnt_en), 32'(e.en));
      chk("cnt_rst_n", n, 32'(cnt_rst_n), 32'(e.crn));
      chk("running", n, 32'(running), 32'(e.st == R));
      chk("done", n, 32'(done), 32'(e.st == D));
      if (e.cnt != 8'hFF) chk("count", n, 32'({tens, units}), 32'(e.cnt));
      if (e.p >= 0) chk("presc", n, 32'(dut.u_tick.presc), 32'(e.p));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/clear controller for the two-digit BCD counter (00–99). It divides the system clock into a one-cycle count-enable strobe and drives the counter's enable and synchronous clear. It watches the counter's BCD outputs and stops at a programmable limit. It sits between the debounced user buttons and the two-digit counter.

## Interface
Parameters:
- `DIV`, default 1_000_000: clock cycles per count step; must be ≥ 2.
- `LIMIT_TENS`, default 5: tens digit of the stop value; 0–9.
- `LIMIT_UNITS`, default 9: units digit of the stop value; 0–9. `{LIMIT_TENS,LIMIT_UNITS}` must be ≠ 00.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: **synchronous, active-low** reset.
- `start_stop` in 1: single-cycle pulse, already debounced; toggles run/pause.
- `clear` in 1: single-cycle pulse; returns the block to idle and zeroes the counter.
- `units` in 4: BCD units digit from the counter.
- `tens` in 4: BCD tens digit from the counter.
- `cnt_en` out 1: one-cycle count strobe to the counter's `en`.
- `cnt_rst_n` out 1: active-low synchronous clear to the counter's `rst_n`.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `state` out 2: current FSM state, for debug.

## Operation
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
- Transitions, evaluated in priority order:
  - `clear` (any state) → IDLE.
  - RUN and `{tens,units}=={LIMIT_TENS,LIMIT_UNITS}` → DONE.
  - IDLE, `start_stop` → RUN.
  - RUN, `start_stop` → PAUSE.
  - PAUSE, `start_stop` → RUN.
  - DONE ignores `start_stop`.
- Prescaler `presc`, width `$clog2(DIV)`:
  - Loaded to 0 on the IDLE→RUN transition, on `clear`, and in IDLE/DONE.
  - Increments on every edge where state==RUN; wraps DIV-1→0.
  - Held (not cleared) in PAUSE, so the partial period is preserved across a pause.
- `cnt_en` is registered: set for one cycle at the edge where state==RUN and `presc==DIV-1`; otherwise 0. It is never set in IDLE, PAUSE or DONE, nor on the edge of a RUN→DONE or clear transition.
- `cnt_rst_n` is registered: driven 0 for exactly one cycle at the edge that samples `clear`; otherwise 1.
- Limit compare is combinational on the `units`/`tens` inputs and evaluated only in RUN. Digits > 9 are never produced by the counter; no checking is required.
- `running` and `done` decode directly from the state register.

## Timing
- Reset values: state=IDLE, presc=0, `cnt_en`=0, `cnt_rst_n`=0, `running`=0, `done`=0.
  - `cnt_rst_n` low during reset holds the counter cleared.
  - `cnt_rst_n` returns to 1 at the first edge with `rst_n`=1.
- Start latency: with `start_stop` sampled at edge E0, `cnt_en` is high in the cycle after edge E(DIV). It then repeats every DIV RUN-state cycles. The counter value changes one edge after each `cnt_en`.
- Limit latency: the counter reaches the limit one edge after `cnt_en`. State is DONE one edge later. DIV ≥ 2 guarantees no further `cnt_en` occurs in between.
- `clear` and `start_stop` in the same cycle: `clear` wins and `start_stop` is dropped.
- `start_stop` arriving on the same edge that detects the limit: DONE wins.
- `rst_n` low mid-operation: all registers take their reset values at that edge, regardless of other inputs.

## Structure
- Package `stopwatch_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} sw_state_t`.
  - Localparam helper for the prescaler width.
- Sub-module `tick_gen`: prescaler with `en` (RUN), `load0` and a `tick` output.
- FSM and output registers live in `stopwatch_ctrl`.
- Top-level integration instantiates `stopwatch_ctrl` beside the two-digit counter and wires `cnt_en`/`cnt_rst_n`.

## Test plan
All scenarios use DIV=4, LIMIT=03, with the real two-digit counter attached.
1. Reset, then `start_stop` at E0 → `cnt_en` high after E4, E8, E12; counter reads 01/02/03 after E5/E9/E13; `done`=1 and `running`=0 after E14; no further `cnt_en`.
2. Start, pause after 2 RUN cycles, idle 10 cycles, resume → no `cnt_en` and `presc` frozen while paused; first `cnt_en` comes 2 RUN cycles after resume.
3. `clear` mid-RUN with counter at 02 → `cnt_rst_n` low exactly 1 cycle; state IDLE; counter 00 next cycle; `cnt_en` stays 0.
4. `clear` and `start_stop` together in IDLE → state stays IDLE; `cnt_rst_n` pulses; no RUN entry.
5. In DONE, pulse `start_stop` 3× → state stays DONE; then `clear` → IDLE and counter 00.
6. `rst_n` low for 1 cycle in RUN at counter 01 → all outputs at reset values; counter 00; `start_stop` afterwards behaves as in scenario 1.
